// File: rtl/ser_bus_master_pkg.sv
// ser_bus_pkg: shared constants and state encoding for ser_bus_master.
//   CMD_*  : host command bytes
//   RSP_*  : single-byte responses
//   state_e: master FSM states
package ser_bus_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_SYNC  = 8'h53;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [1:0] {IDLE, ARG, MEM, RESP} state_e;
endpackage

// File: rtl/ser_bus_master_if.sv
// ser_bus_master_if: byte link (rx/tx) plus native memory bus of the
// serial bus master.
//   master modport: the bridge (drives rx_ready, tx_*, mem_valid/addr/wdata/wstrb, busy)
//   slave modport : byte source/sink and memory responder side
interface ser_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_ready, mem_rdata,
    output rx_ready, tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, mem_ready, mem_rdata,
    input  rx_ready, tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/ser_bus_master_byte_shift32.sv
// byte_shift32: 32-bit LSB-first byte shift register.
//   clk_24, reset : clock, synchronous active-high reset (clears to 0)
//   i_load/i_load_val : parallel load (wins over shift)
//   i_shift/i_byte    : shift right one byte, i_byte enters at [31:24]
//   o_q               : register contents; [7:0] is the next byte out
module byte_shift32 (
  input  logic        clk_24,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_q
);
  logic [31:0] r_q;

  always_ff @(posedge clk_24) begin
    if (reset)        r_q <= '0;
    else if (i_load)  r_q <= i_load_val;
    else if (i_shift) r_q <= {i_byte, r_q[31:8]};
  end

  assign o_q = r_q;
endmodule

// File: rtl/ser_bus_master.sv
// ser_bus_master: byte-stream driven initiator for the native memory bus.
//   clk_24 : system clock
//   reset  : synchronous, active-high
//   bus    : ser_bus_master_if.master (rx byte in, tx byte out, memory bus, busy)
// Frames: 'W' a0..a3 d0..d3 -> write, ACK; 'R' a0..a3 -> read, 4 data
// bytes; 'S' -> ACK; anything else -> NAK. A bus request that sees no
// ready within TIMEOUT_CYCLES is abandoned with a NAK.
module ser_bus_master
  import ser_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_24,
  input  logic             reset,
  ser_bus_master_if.master bus
);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_SAT  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES) : {TW{1'b1}};
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_next;
  logic [2:0]  r_arg_cnt;
  logic        r_is_wr;
  logic [1:0]  r_tx_left;     // bytes still to send after the current one
  logic [TW-1:0] r_to_cnt;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wstrb;

  logic        w_rx_ready, w_tx_valid, w_mem_valid;
  logic        w_rx_fire, w_tx_fire, w_arg_last, w_timeout, w_is_cmd;
  logic [31:0] w_asm_q, w_ser_q, w_ser_load_val;
  logic        w_ser_load;
  logic        w_unused_ser;

  assign w_rx_fire  = w_rx_ready & bus.rx_valid;
  assign w_tx_fire  = w_tx_valid & bus.tx_ready;
  assign w_is_cmd   = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);
  assign w_arg_last = (r_arg_cnt == (r_is_wr ? 3'd7 : 3'd3));
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk_24) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; a ready in the last allowed cycle beats the timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rx_fire) w_next = w_is_cmd ? ARG : RESP;
      ARG:     if (w_rx_fire && w_arg_last) w_next = MEM;
      MEM:     if (bus.mem_ready || w_timeout) w_next = RESP;
      RESP:    if (w_tx_fire && r_tx_left == 2'd0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; rx_ready held low while reset is asserted
  always_comb begin
    w_rx_ready  = !reset && (r_state == IDLE || r_state == ARG);
    w_tx_valid  = (r_state == RESP);
    w_mem_valid = (r_state == MEM);
  end

  // What the serializer is loaded with on entry to RESP
  always_comb begin
    w_ser_load     = 1'b0;
    w_ser_load_val = {24'h0, RSP_NAK};
    case (r_state)
      IDLE: if (w_rx_fire && !w_is_cmd) begin
        w_ser_load     = 1'b1;
        w_ser_load_val = {24'h0, (bus.rx_data == CMD_SYNC) ? RSP_ACK : RSP_NAK};
      end
      MEM: if (bus.mem_ready) begin
        w_ser_load     = 1'b1;
        w_ser_load_val = r_is_wr ? {24'h0, RSP_ACK} : bus.mem_rdata;
      end else if (w_timeout) begin
        w_ser_load     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_arg_cnt   <= '0;
      r_is_wr     <= 1'b0;
      r_tx_left   <= '0;
      r_to_cnt    <= '0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_rx_fire) begin
          r_is_wr   <= (bus.rx_data == CMD_WRITE);
          r_arg_cnt <= '0;
          r_tx_left <= '0;
        end
        ARG: if (w_rx_fire) begin
          r_arg_cnt <= r_arg_cnt + 3'd1;
          // Fourth argument byte completes the address; low 2 bits dropped
          if (r_arg_cnt == 3'd3) r_mem_addr <= {bus.rx_data, w_asm_q[31:10], 2'b00};
          if (w_arg_last) begin
            r_mem_wstrb <= r_is_wr ? 4'hF : 4'h0;
            r_to_cnt    <= '0;
          end
        end
        MEM: begin
          if (r_to_cnt != TO_SAT) r_to_cnt <= r_to_cnt + 1'b1;
          if (bus.mem_ready)  r_tx_left <= r_is_wr ? 2'd0 : 2'd3;
          else if (w_timeout) r_tx_left <= 2'd0;
        end
        RESP: if (w_tx_fire && r_tx_left != 2'd0) r_tx_left <= r_tx_left - 2'd1;
        default: ;
      endcase
    end
  end

  // Argument assembly: after a 'W' frame the last 4 bytes are the write
  // data, and nothing shifts during MEM so wdata stays stable.
  byte_shift32 u_asm (
    .clk_24(clk_24), .reset(reset),
    .i_load(1'b0), .i_load_val(32'h0),
    .i_shift(w_rx_fire && r_state == ARG), .i_byte(bus.rx_data),
    .o_q(w_asm_q)
  );

  // Response serializer: tx_data is the low byte; shifts only on accept
  byte_shift32 u_ser (
    .clk_24(clk_24), .reset(reset),
    .i_load(w_ser_load), .i_load_val(w_ser_load_val),
    .i_shift(w_tx_fire), .i_byte(8'h00),
    .o_q(w_ser_q)
  );

  // Upper serializer bits are only ever shifted down, never read directly
  assign w_unused_ser = |w_ser_q[31:8];

  assign bus.rx_ready  = w_rx_ready;
  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = w_ser_q[7:0];
  assign bus.mem_valid = w_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = w_asm_q;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_ser_bus_master.sv
// tb_ser_bus_master: directed table + randomized frames for ser_bus_master,
// checked against a frame-level reference model (word memory + rules).
module tb_ser_bus_master;
  import ser_bus_pkg::*;

  localparam int TO = 16;

  logic clk_24 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_24 = ~clk_24;

  ser_bus_master_if bus();
  ser_bus_master #(.TIMEOUT_CYCLES(TO)) dut (.clk_24(clk_24), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          vcyc;
    int          unstable;
  } txn_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] raw_addr;
    logic [31:0] data;
    int          lat;       // responder ready delay in cycles; >=TO or 255 never answers in time
    int          stall;     // tx_ready low cycles per byte
    int          exp_txn;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_vcyc;
    int          exp_n;
    logic [31:0] exp_resp;  // response bytes, LSB first
  } vec_t;

  int errors = 0;
  int checks = 0;

  int cfg_lat   = 0;
  int cfg_stall = 0;

  txn_t        txn_q[$];
  logic [7:0]  tx_q[$];
  time         tx_t[$];
  int          stab_bad = 0;
  int          rxr_bad  = 0;
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  time         t_first, t_last;

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: answers cfg_lat cycles after mem_valid rises, logs
  // each request, and toggles mem_ready randomly while no request is open.
  txn_t cur;
  bit   r_act = 1'b0;
  int   r_cnt = 0;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    resp_mem[32'h1000_0000] = 32'h1234_5678;
    forever begin
      @(negedge clk_24);
      if (bus.mem_valid === 1'b1) begin
        if (!r_act) begin
          r_act = 1'b1; r_cnt = 0;
          cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata; cur.wstrb = bus.mem_wstrb;
          cur.vcyc = 0; cur.unstable = 0;
        end else if (bus.mem_addr !== cur.addr || bus.mem_wdata !== cur.wdata ||
                     bus.mem_wstrb !== cur.wstrb) begin
          cur.unstable++;
        end
        cur.vcyc++;
        if (cfg_lat != 255 && r_cnt >= cfg_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = resp_mem.exists(cur.addr) ? resp_mem[cur.addr] : def_word(cur.addr);
          if (cur.wstrb == 4'hF) resp_mem[cur.addr] = cur.wdata;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
        r_cnt++;
      end else begin
        if (r_act) begin r_act = 1'b0; txn_q.push_back(cur); end
        bus.mem_ready = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Byte sink: stalls cfg_stall cycles per byte, logs accepted bytes with
  // the edge time they are taken, and notes held-data or rx_ready violations.
  int         s_cnt  = 0;
  bit         s_held = 1'b0;
  logic [7:0] s_hv   = '0;
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk_24);
      if (bus.tx_valid === 1'b1) begin
        if (s_held && bus.tx_data !== s_hv) stab_bad++;
        if (bus.rx_ready !== 1'b0) rxr_bad++;
        if (s_cnt < cfg_stall) begin
          bus.tx_ready = 1'b0; s_cnt++; s_held = 1'b1; s_hv = bus.tx_data;
        end else begin
          bus.tx_ready = 1'b1; tx_q.push_back(bus.tx_data); tx_t.push_back($time + 5);
          s_cnt = 0; s_held = 1'b0;
        end
      end else begin
        bus.tx_ready = 1'b0; s_cnt = 0; s_held = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit first);
    int n = 0;
    @(negedge clk_24);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 100) begin @(negedge clk_24); n++; end
    chk("rx_ready_wait", {31'h0, bus.rx_ready}, 32'h1);
    @(posedge clk_24);
    if (first) t_first = $time;
    t_last = $time;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    send_byte(c, 1'b1);
    if (c == CMD_WRITE || c == CMD_READ)
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b0);
    if (c == CMD_WRITE)
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b0);
    @(negedge clk_24);
    bus.rx_valid = 1'b0;
  endtask

  // Frame-level reference: word-aligned memory, answer-in-time rule
  function automatic vec_t model(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                                 input int lat, input int st);
    vec_t v;
    logic [31:0] wa;
    bit ok;
    wa = {a[31:2], 2'b00};
    ok = (lat < TO);
    v = '{c, a, d, lat, st, 0, 32'h0, 32'h0, 4'h0, 0, 1, {24'h0, RSP_NAK}};
    if (c == CMD_WRITE || c == CMD_READ) begin
      v.exp_txn = 1; v.exp_addr = wa; v.exp_vcyc = ok ? lat + 1 : TO;
      if (c == CMD_WRITE) begin
        v.exp_wstrb = 4'hF; v.exp_wdata = d;
        if (ok) begin v.exp_resp = {24'h0, RSP_ACK}; ref_mem[wa] = d; end
      end else if (ok) begin
        v.exp_n = 4;
        v.exp_resp = ref_mem.exists(wa) ? ref_mem[wa] : def_word(wa);
      end
    end else if (c == CMD_SYNC) begin
      v.exp_resp = {24'h0, RSP_ACK};
    end
    return v;
  endfunction

  task automatic run_frame(input string tag, input vec_t v);
    int q0, t0, sb0, rb0, n;
    txn_t tr;
    q0 = tx_q.size(); t0 = txn_q.size(); sb0 = stab_bad; rb0 = rxr_bad; n = 0;
    cfg_lat = v.lat; cfg_stall = v.stall;
    send_frame(v.cmd, v.raw_addr, v.data);
    while (n < 400 && !(bus.busy === 1'b0 && bus.mem_valid === 1'b0 && tx_q.size() - q0 >= v.exp_n)) begin
      @(negedge clk_24); n++;
    end
    repeat (3) @(negedge clk_24);
    chk({tag, " idle_after"}, {31'h0, bus.busy}, 32'h0);
    chk({tag, " tx_count"}, 32'(tx_q.size() - q0), 32'(v.exp_n));
    for (int i = 0; i < v.exp_n && q0 + i < tx_q.size(); i++)
      chk($sformatf("%s tx_byte%0d", tag, i), {24'h0, tx_q[q0+i]}, {24'h0, v.exp_resp[8*i +: 8]});
    chk({tag, " txn_count"}, 32'(txn_q.size() - t0), 32'(v.exp_txn));
    if (v.exp_txn != 0 && txn_q.size() > t0) begin
      tr = txn_q[t0];
      chk({tag, " mem_addr"}, tr.addr, v.exp_addr);
      chk({tag, " mem_wstrb"}, {28'h0, tr.wstrb}, {28'h0, v.exp_wstrb});
      chk({tag, " valid_cycles"}, 32'(tr.vcyc), 32'(v.exp_vcyc));
      chk({tag, " req_stable"}, 32'(tr.unstable), 32'h0);
      if (v.exp_wstrb == 4'hF) chk({tag, " mem_wdata"}, tr.wdata, v.exp_wdata);
    end
    chk({tag, " tx_held"}, 32'(stab_bad - sb0), 32'h0);
    chk({tag, " rx_blocked"}, 32'(rxr_bad - rb0), 32'h0);
    if (v.cmd == CMD_WRITE)
      chk({tag, " w_accept_cycles"}, 32'((t_last - t_first) / 10), 32'd8);
    if (v.cmd == CMD_READ && v.lat == 0 && v.stall == 0 && tx_q.size() - q0 >= 4) begin
      chk({tag, " rd_first_byte_lat"}, 32'((tx_t[q0] - t_last) / 10), 32'd2);
      for (int i = 1; i < 4; i++)
        chk($sformatf("%s rd_byte_gap%0d", tag, i), 32'((tx_t[q0+i] - tx_t[q0+i-1]) / 10), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rx_ready"},  {31'h0, bus.rx_ready},  32'h0);
    chk({tag, " tx_valid"},  {31'h0, bus.tx_valid},  32'h0);
    chk({tag, " tx_data"},   {24'h0, bus.tx_data},   32'h0);
    chk({tag, " mem_valid"}, {31'h0, bus.mem_valid}, 32'h0);
    chk({tag, " mem_addr"},  bus.mem_addr,           32'h0);
    chk({tag, " mem_wdata"}, bus.mem_wdata,          32'h0);
    chk({tag, " mem_wstrb"}, {28'h0, bus.mem_wstrb}, 32'h0);
    chk({tag, " busy"},      {31'h0, bus.busy},      32'h0);
  endtask

  vec_t tbl[10];
  vec_t rv;
  initial begin
    bus.rx_data = '0; bus.rx_valid = 1'b0;

    tbl[0] = '{CMD_READ,  32'h1000_0003, 32'h0,         0,   0, 1, 32'h1000_0000, 32'h0,         4'h0, 1,  4, 32'h1234_5678};
    tbl[1] = '{CMD_WRITE, 32'h1000_0000, 32'hDEAD_BEEF, 1,   0, 1, 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 2,  1, 32'h0000_0006};
    tbl[2] = '{CMD_READ,  32'h1000_0001, 32'h0,         2,   5, 1, 32'h1000_0000, 32'h0,         4'h0, 3,  4, 32'hDEAD_BEEF};
    tbl[3] = '{CMD_READ,  32'hF000_0000, 32'h0,         255, 0, 1, 32'hF000_0000, 32'h0,         4'h0, 16, 1, 32'h0000_0015};
    tbl[4] = '{8'h41,     32'h0,         32'h0,         0,   0, 0, 32'h0,         32'h0,         4'h0, 0,  1, 32'h0000_0015};
    tbl[5] = '{CMD_SYNC,  32'h0,         32'h0,         0,   0, 0, 32'h0,         32'h0,         4'h0, 0,  1, 32'h0000_0006};
    tbl[6] = '{CMD_WRITE, 32'h2000_0007, 32'h0BAD_F00D, 15,  1, 1, 32'h2000_0004, 32'h0BAD_F00D, 4'hF, 16, 1, 32'h0000_0006};
    tbl[7] = '{CMD_READ,  32'h2000_0004, 32'h0,         0,   0, 1, 32'h2000_0004, 32'h0,         4'h0, 1,  4, 32'h0BAD_F00D};
    tbl[8] = '{CMD_WRITE, 32'h2000_0008, 32'h1122_3344, 16,  0, 1, 32'h2000_0008, 32'h1122_3344, 4'hF, 16, 1, 32'h0000_0015};
    tbl[9] = '{CMD_READ,  32'h2000_000A, 32'h0,         0,   0, 1, 32'h2000_0008, 32'h0,         4'h0, 1,  4, 32'h7A5A_C3CB};

    repeat (3) @(posedge clk_24);
    @(negedge clk_24);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk_24);
    chk("idle rx_ready", {31'h0, bus.rx_ready}, 32'h1);

    for (int i = 0; i < 10; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Reset in the middle of a write's arguments, then a fresh read
    begin
      int t0;
      t0 = txn_q.size();
      cfg_lat = 0; cfg_stall = 0;
      send_byte(CMD_WRITE, 1'b1);
      send_byte(8'h88, 1'b0); send_byte(8'h77, 1'b0);
      send_byte(8'h66, 1'b0); send_byte(8'h55, 1'b0);
      @(negedge clk_24);
      bus.rx_valid = 1'b0;
      chk("midarg busy", {31'h0, bus.busy}, 32'h1);
      reset = 1'b1;
      @(negedge clk_24);
      chk_reset_vals("midarg_reset");
      reset = 1'b0;
      repeat (2) @(negedge clk_24);
      chk("midarg no_txn", 32'(txn_q.size() - t0), 32'h0);
      run_frame("after_reset", '{CMD_READ, 32'h1000_0000, 32'h0, 1, 0, 1, 32'h1000_0000,
                                 32'h0, 4'h0, 2, 4, 32'hDEAD_BEEF});
    end

    // Random frames in a region the directed table does not touch
    for (int k = 0; k < 40; k++) begin
      logic [7:0]  c;
      logic [31:0] a;
      int pick, lat;
      pick = $urandom_range(0, 9);
      if (pick < 4)      c = CMD_WRITE;
      else if (pick < 8) c = CMD_READ;
      else if (pick == 8) c = CMD_SYNC;
      else begin
        c = 8'($urandom);
        while (c == CMD_WRITE || c == CMD_READ || c == CMD_SYNC) c = 8'($urandom);
      end
      a = 32'h3000_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      pick = $urandom_range(0, 9);
      if (pick < 7)       lat = $urandom_range(0, 3);
      else if (pick == 7) lat = TO - 1;
      else if (pick == 8) lat = TO;
      else                lat = 255;
      rv = model(c, a, $urandom, lat, $urandom_range(0, 2));
      run_frame($sformatf("rnd%0d", k), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
